// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction memory request/response bus
//
// Purpose: SRAM-like fetch bus between the fetch controller and instruction memory.
// Signals:
//   imem_req      fetch request (master -> slave)
//   imem_addr     fetch address (master -> slave)
//   imem_addr_ok  request accepted this cycle (slave -> master)
//   imem_data_ok  read data valid this cycle (slave -> master)
//   imem_rdata    read data (slave -> master)
interface pc_fetch_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_addr_ok;
  logic             imem_data_ok;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_addr_ok,
    input  imem_data_ok,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_addr_ok,
    output imem_data_ok,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC sequencing and instruction fetch handshake
//
// Purpose: owns the PC, picks the next PC (exception > eret > branch > PC+4),
// issues one fetch at a time and holds the fetched instruction for decode.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   stall                  decode cannot accept the held instruction
//   exc_valid              redirect to EXC_PC
//   eret_valid, eret_pc    redirect to EPC
//   br_valid, br_target    branch/jump redirect
//   imem                   fetch bus (master side)
//   inst_valid, inst,      instruction handed to decode
//   inst_pc, inst_adel     its PC and misaligned-fetch flag (inst forced to 0)
module pc_fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [WIDTH-1:0] EXC_PC   = 32'hBFC0_0380
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] eret_pc,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  pc_fetch_ctrl_if.master  imem,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_adel
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] pc;
  logic             kill;       // outstanding fetch belongs to a squashed PC
  logic             redir;
  logic [WIDTH-1:0] redir_pc;
  logic             pc_misaligned;

  assign redir         = exc_valid | eret_valid | br_valid;
  assign pc_misaligned = |pc[1:0];

  always_comb begin
    redir_pc = br_target;
    if (eret_valid) redir_pc = eret_pc;
    if (exc_valid)  redir_pc = EXC_PC;
  end

  // The request is suppressed during a redirect so nothing is issued to the
  // stale PC, and for a misaligned PC, which turns into an AdEL instead.
  assign imem.imem_req  = (state == ST_REQ) && !redir && !pc_misaligned;
  assign imem.imem_addr = pc;
  assign inst_valid     = (state == ST_HOLD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      inst      <= '0;
      inst_pc   <= '0;
      inst_adel <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          // Redirects are not sampled here.
          state <= ST_REQ;
        end

        ST_REQ: begin
          if (redir) begin
            pc <= redir_pc;
          end else if (pc_misaligned) begin
            inst      <= '0;
            inst_pc   <= pc;
            inst_adel <= 1'b1;
            state     <= ST_HOLD;
          end else if (imem.imem_addr_ok) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (imem.imem_data_ok) begin
            // The transaction retires now; any redirect this cycle needs no kill.
            kill <= 1'b0;
            if (redir) begin
              pc    <= redir_pc;
              state <= ST_REQ;
            end else if (kill) begin
              state <= ST_REQ;
            end else begin
              inst      <= imem.imem_rdata;
              inst_pc   <= pc;
              inst_adel <= 1'b0;
              state     <= ST_HOLD;
            end
          end else if (redir) begin
            // Last redirect wins while the squashed fetch is still in flight.
            pc   <= redir_pc;
            kill <= 1'b1;
          end
        end

        ST_HOLD: begin
          // A redirect flushes decode in the same cycle, so it beats accept.
          if (redir) begin
            pc    <= redir_pc;
            state <= ST_REQ;
          end else if (!stall) begin
            pc    <= pc + WIDTH'(4);
            state <= ST_REQ;
          end
        end

        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed and randomized bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC  = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        exc_valid = 1'b0;
  logic        eret_valid = 1'b0;
  logic [31:0] eret_pc = '0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_adel;

  pc_fetch_ctrl_if #(.WIDTH(32)) imem ();

  pc_fetch_ctrl #(
    .WIDTH(32),
    .RESET_PC(RST_PC),
    .EXC_PC(EXC_VEC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .stall(stall),
    .exc_valid(exc_valid),
    .eret_valid(eret_valid),
    .eret_pc(eret_pc),
    .br_valid(br_valid),
    .br_target(br_target),
    .imem(imem),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_adel(inst_adel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model: one outstanding read, data_ok lat+1 cycles after acceptance
  logic        mem_busy;
  int          mem_lat;
  logic [31:0] mem_data;
  int          ok_pct = 100;
  int          lat_lo = 0;
  int          lat_hi = 0;

  // architectural reference: the PC the front end should be presenting
  logic        boot;
  logic [31:0] model_pc;
  int          idle;
  logic        prev_hold;
  logic [31:0] prev_inst;
  logic [31:0] prev_pc;
  logic        prev_adel;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_inst;
  logic [31:0] s_pc;
  logic        s_adel;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a << 2;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    boot      = 1'b1;
    model_pc  = RST_PC;
    mem_busy  = 1'b0;
    mem_lat   = 0;
    mem_data  = '0;
    idle      = 0;
    prev_hold = 1'b0;
  endtask

  // One clock cycle: entered just after a negedge with inputs already driven.
  task automatic step();
    logic        redir;
    logic [31:0] tgt;
    logic        acc;
    #1;
    imem.imem_addr_ok = 1'b0;
    imem.imem_data_ok = 1'b0;
    imem.imem_rdata   = 32'hDEAD_BEEF;
    if (mem_busy && mem_lat == 0) begin
      imem.imem_data_ok = 1'b1;
      imem.imem_rdata   = mem_data;
    end
    if (imem.imem_req && ($urandom_range(1, 100) <= ok_pct)) imem.imem_addr_ok = 1'b1;
    #1;
    s_req   = imem.imem_req;
    s_addr  = imem.imem_addr;
    s_valid = inst_valid;
    s_inst  = inst;
    s_pc    = inst_pc;
    s_adel  = inst_adel;
    acc     = s_req && imem.imem_addr_ok;
    redir   = !boot && (exc_valid || eret_valid || br_valid);
    tgt     = exc_valid ? EXC_VEC : (eret_valid ? eret_pc : br_target);

    if (s_req) begin
      chk("req_addr", s_addr, model_pc);
      chk("req_while_outstanding", {31'd0, mem_busy}, 32'd0);
    end
    if (exc_valid || eret_valid || br_valid) chk("req_during_redirect", {31'd0, s_req}, 32'd0);
    if (model_pc[1:0] != 2'b00) chk("req_misaligned", {31'd0, s_req}, 32'd0);
    if (prev_hold) begin
      chk("stall_keeps_valid", {31'd0, s_valid}, 32'd1);
      chk("stall_inst_stable", s_inst, prev_inst);
      chk("stall_pc_stable", s_pc, prev_pc);
      chk("stall_adel_stable", {31'd0, s_adel}, {31'd0, prev_adel});
    end
    if (s_valid) begin
      chk("inst_pc", s_pc, model_pc);
      chk("inst_data", s_inst, (model_pc[1:0] != 2'b00) ? 32'd0 : word_at(model_pc));
      chk("inst_adel", {31'd0, s_adel}, {31'd0, (model_pc[1:0] != 2'b00)});
      idle = 0;
    end else begin
      idle++;
    end
    if (idle > 150) begin
      chk("watchdog_idle_cycles", idle, 32'd150);
      idle = 0;
    end
    prev_hold = s_valid && stall && !redir;
    prev_inst = s_inst;
    prev_pc   = s_pc;
    prev_adel = s_adel;

    @(posedge clk);
    if (boot) boot = 1'b0;
    else if (redir) model_pc = tgt;
    else if (s_valid && !stall) model_pc = model_pc + 32'd4;
    if (mem_busy) begin
      if (mem_lat == 0) mem_busy = 1'b0;
      else mem_lat--;
    end
    if (acc) begin
      mem_busy = 1'b1;
      mem_lat  = $urandom_range(lat_lo, lat_hi);
      mem_data = word_at(s_addr);
    end
    @(negedge clk);
    imem.imem_addr_ok = 1'b0;
    imem.imem_data_ok = 1'b0;
  endtask

  initial begin
    imem.imem_addr_ok = 1'b0;
    imem.imem_data_ok = 1'b0;
    imem.imem_rdata   = '0;
    reset_model();
    repeat (2) @(negedge clk);

    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_adel", {31'd0, inst_adel}, 32'd0);

    resetn = 1'b1;
    step(); chk("boot_no_req", {31'd0, s_req}, 32'd0);
    step(); chk("first_req", {31'd0, s_req}, 32'd1); chk("first_addr", s_addr, RST_PC);
    step(); chk("wait_no_valid", {31'd0, s_valid}, 32'd0);
    step(); chk("first_valid", {31'd0, s_valid}, 32'd1); chk("first_inst_pc", s_pc, RST_PC);
    step(); chk("seq_req", {31'd0, s_req}, 32'd1); chk("seq_addr", s_addr, RST_PC + 32'd4);
    step();

    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", {31'd0, s_valid}, 32'd1);
      chk("stall_inst_pc", s_pc, RST_PC + 32'd4);
      chk("stall_no_req", {31'd0, s_req}, 32'd0);
    end
    stall = 1'b0;
    step(); chk("accept_valid", {31'd0, s_valid}, 32'd1);
    lat_lo = 2; lat_hi = 2;
    step(); chk("after_stall_req", {31'd0, s_req}, 32'd1); chk("after_stall_addr", s_addr, RST_PC + 32'd8);

    br_valid = 1'b1; br_target = 32'h8000_1000;
    step(); chk("squash_w1_valid", {31'd0, s_valid}, 32'd0);
    br_valid = 1'b0; br_target = 32'h1234_5678;
    step(); chk("squash_w2_valid", {31'd0, s_valid}, 32'd0);
    lat_lo = 0; lat_hi = 0;
    step(); chk("squash_data_valid", {31'd0, s_valid}, 32'd0);
    step(); chk("br_req", {31'd0, s_req}, 32'd1); chk("br_addr", s_addr, 32'h8000_1000);
    chk("br_req_valid", {31'd0, s_valid}, 32'd0);

    exc_valid = 1'b1; eret_valid = 1'b1; eret_pc = 32'h8000_0200;
    br_valid = 1'b1; br_target = 32'h8000_3000;
    step(); chk("prio_cycle_no_req", {31'd0, s_req}, 32'd0);
    exc_valid = 1'b0; eret_valid = 1'b0; br_valid = 1'b0;
    step(); chk("prio_addr", s_addr, EXC_VEC); chk("prio_req", {31'd0, s_req}, 32'd1);
    chk("prio_no_valid", {31'd0, s_valid}, 32'd0);
    step();

    eret_valid = 1'b1; eret_pc = 32'h8000_0102;
    step(); chk("exc_inst_pc", s_pc, EXC_VEC);
    eret_valid = 1'b0;
    step(); chk("adel_no_req", {31'd0, s_req}, 32'd0);
    br_valid = 1'b1; br_target = 32'h8000_0040;
    step();
    chk("adel_valid", {31'd0, s_valid}, 32'd1);
    chk("adel_flag", {31'd0, s_adel}, 32'd1);
    chk("adel_inst", s_inst, 32'd0);
    chk("adel_inst_pc", s_pc, 32'h8000_0102);
    br_valid = 1'b0;
    lat_lo = 5; lat_hi = 5;
    step(); chk("recover_addr", s_addr, 32'h8000_0040);
    step();

    #3 resetn = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst_inst", inst, 32'd0);
    chk("midrst_inst_pc", inst_pc, 32'd0);
    chk("midrst_adel", {31'd0, inst_adel}, 32'd0);
    reset_model();
    lat_lo = 0; lat_hi = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    br_valid = 1'b1; br_target = 32'h8000_4000;
    step(); chk("restart_boot_no_req", {31'd0, s_req}, 32'd0);
    br_valid = 1'b0;
    step(); chk("restart_addr", s_addr, RST_PC); chk("restart_req", {31'd0, s_req}, 32'd1);

    ok_pct = 70; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      stall      = ($urandom_range(0, 2) == 0);
      exc_valid  = ($urandom_range(0, 99) == 0);
      eret_valid = ($urandom_range(0, 59) == 0);
      br_valid   = ($urandom_range(0, 24) == 0);
      eret_pc    = rand_target();
      br_target  = rand_target();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the MIPS pipeline front end.
- Owns the PC register and selects the next PC by priority: exception > eret > branch redirect > sequential PC+4.
- Issues one fetch at a time over an SRAM-like request/addr_ok/data_ok interface.
- Holds the fetched instruction for the decode stage under stall, and squashes in-flight fetches when a redirect arrives.

Parameters:
- WIDTH, 32, address/data width.
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- EXC_PC, 32'hBFC0_0380, exception vector.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- stall  in  1  decode cannot accept; held instruction must stay stable.
- exc_valid  in  1  exception redirect to EXC_PC.
- eret_valid  in  1  eret redirect.
- eret_pc  in  WIDTH  eret target (EPC).
- br_valid  in  1  branch/jump redirect.
- br_target  in  WIDTH  branch target.
- imem_req  out  1  fetch request.
- imem_addr  out  WIDTH  fetch address.
- imem_addr_ok  in  1  request accepted this cycle.
- imem_data_ok  in  1  read data valid this cycle.
- imem_rdata  in  WIDTH  read data.
- inst_valid  out  1  inst/inst_pc valid for decode.
- inst  out  WIDTH  fetched instruction.
- inst_pc  out  WIDTH  PC of inst.
- inst_adel  out  1  fetch address misaligned (AdEL); inst forced to 0.

Behaviour:
- Clock and reset: one clock domain. resetn is asynchronous and active-low.
- Reset values: pc=RESET_PC, state=BOOT, imem_req=0, inst_valid=0, inst=0, inst_pc=0, inst_adel=0, kill=0.
- States:
  - BOOT: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - WAIT: request accepted, awaiting data_ok.
  - HOLD: inst_valid=1, instruction registered.
- Redirect: redir = exc_valid | eret_valid | br_valid. Target chosen by priority exc > eret > br. Redirect is sampled in every state except BOOT; a redirect during BOOT is ignored.
- REQ, no redirect:
  - pc[1:0]!=0: no request issued (imem_req=0). Next cycle goes to HOLD with inst=0, inst_pc=pc, inst_adel=1.
  - imem_addr_ok=1: go to WAIT.
- REQ with redirect: pc<=target. Stay in REQ. imem_req is forced 0 that cycle, so no transaction is issued to a stale address.
- WAIT:
  - imem_data_ok=1 and kill=0: inst<=imem_rdata, inst_pc<=pc, inst_adel=0, go to HOLD.
  - imem_data_ok=1 and kill=1: discard data, kill<=0, go to REQ.
  - Redirect: pc<=target, kill<=1.
  - Redirect in the same cycle as data_ok: data discarded, go to REQ at target.
  - Repeated redirects while kill=1: target overwritten (last wins), kill stays 1.
- HOLD:
  - inst_valid=1, outputs stable while stall=1.
  - stall=0 (accept): pc<=pc+4 (mod 2^WIDTH, wraps), go to REQ.
  - Redirect, with or without stall: held instruction dropped, pc<=target, go to REQ. Redirect takes precedence over accept; the redirecting stage flushes decode in that cycle.
- Latency: with zero-wait memory (addr_ok same cycle as req, data_ok next cycle), the first inst_valid appears 3 cycles after reset release. Steady state is one instruction per 3 cycles (REQ, WAIT, HOLD). A redirect adds no extra cycles beyond the squash.
- Ordering: at most one outstanding transaction. data_ok received in REQ or HOLD is a protocol error and is ignored.
- Reset mid-operation: all state cleared immediately, including kill. The memory side is reset together, so no stale data_ok is expected.

Test Plan:
- Reset release, zero-wait memory returning addr<<2 as data -> imem_addr=BFC00000 in cycle 1; inst_valid in cycle 3 with inst_pc=BFC00000; next fetch at BFC00004.
- stall=1 for 5 cycles while in HOLD -> inst/inst_pc unchanged; imem_req=0; after release, one PC+4 fetch issued.
- br_valid with target 80001000 during WAIT; data_ok 2 cycles later -> that data discarded, inst_valid stays 0; next request addr=80001000.
- exc_valid, eret_valid (eret_pc 80000200) and br_valid asserted in the same cycle -> next imem_addr=BFC00380.
- eret_pc=80000102 -> no imem_req issued; inst_valid=1, inst_adel=1, inst=0, inst_pc=80000102.
- resetn deasserted while in WAIT -> outputs at reset values immediately; after release, fetch restarts at BFC00000.
